// File: rtl/axi_lite_regs_term.sv
// AXI4-Lite register bank terminator: flat bank of NumRegs words, exported
// to hardware, with byte-strobed writes, hardware loads and SLVERR on bad/RO access.
// Ports: clk_i, rst_ni (sync, active-low), slv_req_i/slv_resp_o (AXI-Lite),
// reg_q_o (register values), reg_wr_o (write pulses), reg_load_i/reg_d_i (hw load).

package axi_lite_regs_term_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axil_ax_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axil_w_t;
  typedef struct packed {
    logic [1:0] resp;
  } axil_b_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axil_r_t;
  typedef struct packed {
    axil_ax_t aw;
    logic     aw_valid;
    axil_w_t  w;
    logic     w_valid;
    logic     b_ready;
    axil_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axil_req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    axil_b_t b;
    logic    b_valid;
    logic    ar_ready;
    axil_r_t r;
    logic    r_valid;
  } axil_rsp_t;
endpackage

module axi_lite_regs_term
  import axi_lite_regs_term_pkg::*;
#(
  parameter int unsigned NumRegs   = 8,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter logic [NumRegs-1:0] RoMask = '0,
  parameter logic [NumRegs-1:0][DataWidth-1:0] RegRstVal = '0,
  parameter type axi_lite_req_t = axil_req_t,
  parameter type axi_lite_rsp_t = axil_rsp_t
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  axi_lite_req_t                     slv_req_i,
  output axi_lite_rsp_t                     slv_resp_o,
  output logic [NumRegs-1:0][DataWidth-1:0] reg_q_o,
  output logic [NumRegs-1:0]                reg_wr_o,
  input  logic [NumRegs-1:0]                reg_load_i,
  input  logic [NumRegs-1:0][DataWidth-1:0] reg_d_i
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic [NumRegs-1:0][DataWidth-1:0] reg_q;
  logic [NumRegs-1:0]                reg_wr;

  logic                 aw_held;
  logic [AddrWidth-1:0] aw_addr;
  logic                 w_held;
  logic [DataWidth-1:0] w_data;
  logic [StrbW-1:0]     w_strb;
  logic                 b_valid;
  logic [1:0]           b_resp;
  logic                 r_valid;
  logic [DataWidth-1:0] r_data;
  logic [1:0]           r_resp;

  logic aw_ready, w_ready, ar_ready;
  logic aw_hs, w_hs, ar_hs;
  logic commit;

  logic [NumRegs-1:0]   aw_hit, ar_hit, wr_en;
  logic                 wr_ok, rd_ok;
  logic [DataWidth-1:0] rd_data;

  logic unused_prot;
  assign unused_prot = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

  // One-hot word decode over the full address; out-of-range gives all-zero.
  function automatic logic [NumRegs-1:0] dec(
    input logic [AddrWidth-1:0] a
  );
    logic [AddrWidth-1:0] word;
    dec  = '0;
    word = a >> OffW;
    for (int i = 0; i < NumRegs; i++) begin
      if (word == AddrWidth'(i)) dec[i] = 1'b1;
    end
  endfunction

  assign aw_ready = rst_ni & ~aw_held & ~b_valid;
  assign w_ready  = rst_ni & ~w_held & ~b_valid;
  assign ar_ready = rst_ni & ~r_valid;

  assign aw_hs = aw_ready & slv_req_i.aw_valid;
  assign w_hs  = w_ready & slv_req_i.w_valid;
  assign ar_hs = ar_ready & slv_req_i.ar_valid;

  assign commit = aw_held & w_held & ~b_valid;

  assign aw_hit = dec(aw_addr);
  assign wr_ok  = |(aw_hit & ~RoMask);
  assign wr_en  = (commit && wr_ok) ? aw_hit : '0;

  assign ar_hit = dec(slv_req_i.ar.addr);
  assign rd_ok  = |ar_hit;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NumRegs; i++) begin
      rd_data = rd_data | (reg_q[i] & {DataWidth{ar_hit[i]}});
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg_q   <= RegRstVal;
      reg_wr  <= '0;
      aw_held <= 1'b0;
      aw_addr <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      b_valid <= 1'b0;
      b_resp  <= RespOkay;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RespOkay;
    end else begin
      reg_wr <= wr_en;

      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= slv_req_i.aw.addr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= slv_req_i.w.data;
        w_strb <= slv_req_i.w.strb;
      end

      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= wr_ok ? RespOkay : RespSlverr;
      end else if (b_valid && slv_req_i.b_ready) begin
        b_valid <= 1'b0;
      end

      if (ar_hs) begin
        r_valid <= 1'b1;
        r_data  <= rd_data;
        r_resp  <= rd_ok ? RespOkay : RespSlverr;
      end else if (r_valid && slv_req_i.r_ready) begin
        r_valid <= 1'b0;
      end

      // Bus write beats a same-edge hardware load.
      for (int i = 0; i < NumRegs; i++) begin
        if (wr_en[i]) begin
          for (int k = 0; k < StrbW; k++) begin
            if (w_strb[k]) reg_q[i][8*k +: 8] <= w_data[8*k +: 8];
          end
        end else if (reg_load_i[i]) begin
          reg_q[i] <= reg_d_i[i];
        end
      end
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b.resp   = b_resp;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r.data   = r_data;
    slv_resp_o.r.resp   = r_resp;
    slv_resp_o.r_valid  = r_valid;
  end

  assign reg_q_o  = reg_q;
  assign reg_wr_o = reg_wr;

endmodule

// File: tb/tb_axi_lite_regs_term.sv
// Scoreboard bench for axi_lite_regs_term.
// Responses are queued at issue time and popped at the B/R handshakes.

module tb_axi_lite_regs_term;
  import axi_lite_regs_term_pkg::*;

  localparam logic [7:0] RO = 8'h80;
  localparam logic [7:0][31:0] RST = {
    32'h7777_7777, 32'h0, 32'h0, 32'h0,
    32'h0000_0005, 32'h0, 32'hAAAA_AAAA, 32'h0
  };

  logic clk, rst_n;
  axil_req_t req;
  axil_rsp_t rsp;
  logic [7:0][31:0] reg_q, reg_d;
  logic [7:0] reg_wr, reg_load;

  logic [31:0] aw_addr, ar_addr, w_data;
  logic [3:0]  w_strb;
  logic aw_valid, w_valid, ar_valid, b_ready, r_ready;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [7:0][31:0] model;

  always_comb begin
    req          = '0;
    req.aw.addr  = aw_addr;
    req.aw_valid = aw_valid;
    req.w.data   = w_data;
    req.w.strb   = w_strb;
    req.w_valid  = w_valid;
    req.b_ready  = b_ready;
    req.ar.addr  = ar_addr;
    req.ar_valid = ar_valid;
    req.r_ready  = r_ready;
  end

  axi_lite_regs_term #(
    .NumRegs  (8),
    .AddrWidth(32),
    .DataWidth(32),
    .RoMask   (RO),
    .RegRstVal(RST)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (req),
    .slv_resp_o(rsp),
    .reg_q_o   (reg_q),
    .reg_wr_o  (reg_wr),
    .reg_load_i(reg_load),
    .reg_d_i   (reg_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      wr_pulses += $countones(reg_wr);
      if (rsp.b_valid && b_ready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", rsp.b.resp, exp_b.pop_front());
      end
      if (rsp.r_valid && r_ready) begin
        if (exp_r.size() == 0) begin
          chk("r_unexpected", 1, 0);
        end else begin
          logic [33:0] e;
          e = exp_r.pop_front();
          chk("rdata", rsp.r.data, e[33:2]);
          chk("rresp", rsp.r.resp, e[1:0]);
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    logic done;
    done = 1'b0;
    aw_addr = a;
    aw_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = rsp.aw_ready;
      @(posedge clk); #1;
    end
    aw_valid = 1'b0;
    if (!done) chk("aw_timeout", 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic done;
    done = 1'b0;
    w_data = d;
    w_strb = s;
    w_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = rsp.w_ready;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    if (!done) chk("w_timeout", 0, 1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    logic done;
    done = 1'b0;
    ar_addr = a;
    ar_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      done = rsp.ar_ready;
      @(posedge clk); #1;
    end
    ar_valid = 1'b0;
    if (!done) chk("ar_timeout", 0, 1);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] resp);
    exp_r.push_back({d, resp});
    send_ar(a);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = (exp_b.size() == 0) && (exp_r.size() == 0) &&
           !rsp.b_valid && !rsp.r_valid;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int p;
    rst_n = 1'b0;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    aw_addr = 0; ar_addr = 0; w_data = 0; w_strb = 0;
    b_ready = 1; r_ready = 1;
    reg_load = '0; reg_d = '0;
    model = RST;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", rsp.aw_ready, 0);
    chk("rst_w_ready", rsp.w_ready, 0);
    chk("rst_ar_ready", rsp.ar_ready, 0);
    chk("rst_b_valid", rsp.b_valid, 0);
    chk("rst_r_valid", rsp.r_valid, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_regs", reg_q, model);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_aw_ready", rsp.aw_ready, 1);
    @(posedge clk); #1;

    // full write, same-cycle AW/W
    p = wr_pulses;
    write(32'h8, 32'hDEAD_BEEF, 4'hF, 2'b00);
    model[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lat_b_n1", rsp.b_valid, 0);
    @(negedge clk);
    chk("lat_b_n2", rsp.b_valid, 1);
    chk("wr_pulse2", reg_wr, 8'h04);
    chk("reg2", reg_q[2], 32'hDEAD_BEEF);
    wait_idle();
    chk("pulse_cnt", wr_pulses - p, 1);

    // W three cycles before AW
    exp_b.push_back(2'b00);
    send_w(32'h1122_3344, 4'b0101);
    repeat (3) begin
      @(negedge clk);
      chk("w_ready_held", rsp.w_ready, 0);
    end
    @(posedge clk); #1;
    send_aw(32'h4);
    model[1] = merge(model[1], 32'h1122_3344, 4'b0101);
    wait_idle();
    chk("reg1_strb", reg_q[1], 32'hAA22_AA44);

    // errors
    write(32'h20, 32'h1234_5678, 4'hF, 2'b10);
    wait_idle();
    chk("oor_regs", reg_q, model);
    p = wr_pulses;
    write(32'h1C, 32'h1234_5678, 4'hF, 2'b10);
    wait_idle();
    chk("ro_regs", reg_q, model);
    chk("ro_no_pulse", wr_pulses - p, 0);
    read(32'h20, 32'h0, 2'b10);
    read(32'h4, 32'hAA22_AA44, 2'b00);
    read(32'h1E, 32'h7777_7777, 2'b00);
    wait_idle();

    // zero strobe still pulses
    p = wr_pulses;
    write(32'h10, 32'hFFFF_FFFF, 4'h0, 2'b00);
    wait_idle();
    chk("zs_regs", reg_q, model);
    chk("zs_pulse", wr_pulses - p, 1);

    // B backpressure
    b_ready = 1'b0;
    write(32'h0, 32'h1234_5678, 4'hF, 2'b00);
    model[0] = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_b_valid", rsp.b_valid, 1);
      chk("bp_b_resp", rsp.b.resp, 0);
      chk("bp_aw_ready", rsp.aw_ready, 0);
      chk("bp_w_ready", rsp.w_ready, 0);
    end
    @(posedge clk); #1;
    b_ready = 1'b1;
    wait_idle();

    // R backpressure
    r_ready = 1'b0;
    read(32'h0, 32'h1234_5678, 2'b00);
    repeat (5) begin
      @(negedge clk);
      chk("bp_r_valid", rsp.r_valid, 1);
      chk("bp_r_data", rsp.r.data, 32'h1234_5678);
      chk("bp_ar_ready", rsp.ar_ready, 0);
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    wait_idle();

    // read colliding with write commit on reg3
    write(32'hC, 32'h7, 4'hF, 2'b00);
    read(32'hC, 32'h5, 2'b00);
    model[3] = 32'h7;
    wait_idle();
    chk("coll_reg3", reg_q[3], 32'h7);

    // load colliding with write commit on reg3
    write(32'hC, 32'h7, 4'hF, 2'b00);
    reg_load[3] = 1'b1;
    reg_d[3] = 32'h9;
    @(posedge clk); #1;
    reg_load = '0;
    wait_idle();
    chk("load_coll_reg3", reg_q[3], 32'h7);

    // plain load on RO register, no pulse
    p = wr_pulses;
    reg_load[7] = 1'b1;
    reg_d[7] = 32'h55;
    @(posedge clk); #1;
    reg_load = '0;
    model[7] = 32'h55;
    @(negedge clk);
    chk("load_regs", reg_q, model);
    @(negedge clk);
    chk("load_no_pulse", wr_pulses - p, 0);
    @(posedge clk); #1;

    // reset with AW held
    send_aw(32'h4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model = RST;
    @(negedge clk);
    chk("mid_aw_ready", rsp.aw_ready, 1);
    chk("mid_w_ready", rsp.w_ready, 1);
    chk("mid_b_valid", rsp.b_valid, 0);
    chk("mid_regs", reg_q, model);
    @(posedge clk); #1;
    send_w(32'hCAFE_F00D, 4'hF);
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_commit", rsp.b_valid, 0);
    end
    @(posedge clk); #1;
    exp_b.push_back(2'b00);
    send_aw(32'h8);
    model[2] = 32'hCAFE_F00D;
    wait_idle();
    chk("final_regs", reg_q, model);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
